// File: rtl/brg_cgra_link_arbiter_pkg.sv
// Shared types and width helpers for the CGRA link arbiter.
// Imported by the interface, the round-robin picker and the top.
package brg_cgra_link_arbiter_pkg;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // Id width that stays at least one bit wide even for a single requester.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Bits needed to hold the value n itself.
    function automatic int width_of(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/brg_cgra_link_arbiter_if.sv
// Bundle of requester, forward-link and response signals around the arbiter.
// master drives the requests and responses; slave is the arbiter itself.
interface brg_cgra_link_arbiter_if #(
    parameter int num_req_p         = 4,
    parameter int pkt_width_p       = 128,
    parameter int rsp_width_p       = 64,
    parameter int max_out_credits_p = 16
);
    import brg_cgra_link_arbiter_pkg::*;

    localparam int lg_num_req_lp   = safe_clog2(num_req_p);
    localparam int credit_width_lp = width_of(max_out_credits_p);

    logic [num_req_p-1:0]                  req_v_i;
    logic [num_req_p-1:0][pkt_width_p-1:0] req_pkt_i;
    logic [num_req_p-1:0]                  req_yumi_o;
    logic                                  out_v_o;
    logic [pkt_width_p-1:0]                out_pkt_o;
    logic [lg_num_req_lp-1:0]              out_id_o;
    logic                                  out_ready_i;
    logic                                  rsp_v_i;
    logic [lg_num_req_lp-1:0]              rsp_id_i;
    logic [rsp_width_p-1:0]                rsp_data_i;
    logic [num_req_p-1:0]                  rsp_v_o;
    logic [rsp_width_p-1:0]                rsp_data_o;
    logic [credit_width_lp-1:0]            credits_o;
    logic                                  idle_o;

    modport master (
        output req_v_i, req_pkt_i, out_ready_i, rsp_v_i, rsp_id_i, rsp_data_i,
        input  req_yumi_o, out_v_o, out_pkt_o, out_id_o, rsp_v_o, rsp_data_o,
               credits_o, idle_o
    );

    modport slave (
        input  req_v_i, req_pkt_i, out_ready_i, rsp_v_i, rsp_id_i, rsp_data_i,
        output req_yumi_o, out_v_o, out_pkt_o, out_id_o, rsp_v_o, rsp_data_o,
               credits_o, idle_o
    );

endinterface

// File: rtl/brg_cgra_link_arbiter_rr.sv
// Round-robin picker: first valid requester at or after the priority pointer.
// The pointer advances past the winner only when the grant is taken.
module brg_cgra_link_arbiter_rr
    import brg_cgra_link_arbiter_pkg::*;
#(
    parameter int num_req_p = 4,
    localparam int lg_num_req_lp = safe_clog2(num_req_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [num_req_p-1:0]     v_i,
    input  logic                     yumi_i,
    output logic [num_req_p-1:0]     grant_o,
    output logic [lg_num_req_lp-1:0] id_o
);

    logic [lg_num_req_lp-1:0] ptr_r;

    always_comb begin : search
        logic                     found;
        logic [lg_num_req_lp-1:0] idx;
        grant_o = '0;
        id_o    = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < num_req_p; k++) begin
            idx = lg_num_req_lp'(rr_index(int'(ptr_r), k, num_req_p));
            if (!found && v_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                id_o         = idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_r <= '0;
        end else if (yumi_i) begin
            ptr_r <= lg_num_req_lp'(rr_index(int'(id_o), 1, num_req_p));
        end
    end

endmodule

// File: rtl/brg_cgra_link_arbiter.sv
// Shares one manycore forward link among CGRA requesters, gated by a
// credit counter, and steers responses back by requester id.
//
// state     | meaning
// OUT_EMPTY | no packet held, a grant may be taken
// OUT_FULL  | packet held on out_pkt_o until out_ready_i
module brg_cgra_link_arbiter
    import brg_cgra_link_arbiter_pkg::*;
#(
    parameter int num_req_p         = 4,
    parameter int pkt_width_p       = 128,
    parameter int rsp_width_p       = 64,
    parameter int max_out_credits_p = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    brg_cgra_link_arbiter_if.slave link
);

    localparam int lg_num_req_lp   = safe_clog2(num_req_p);
    localparam int credit_width_lp = width_of(max_out_credits_p);
    localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);
    localparam logic [credit_width_lp-1:0] one_credit_lp  = credit_width_lp'(1);

    out_state_e                 state_r;
    logic [pkt_width_p-1:0]     out_pkt_r;
    logic [lg_num_req_lp-1:0]   out_id_r;
    logic [credit_width_lp-1:0] credits_r;

    logic                       can_accept;
    logic                       grant_en;
    logic                       rsp_ok;
    logic [num_req_p-1:0]       grant_oh;
    logic [lg_num_req_lp-1:0]   grant_id;

    // A full stage still accepts when it drains this cycle (pass-through).
    assign can_accept = (state_r == OUT_EMPTY) || link.out_ready_i;
    assign grant_en   = !reset_i && can_accept && (credits_r != '0) && (|link.req_v_i);
    assign rsp_ok     = link.rsp_v_i && (32'(link.rsp_id_i) < 32'(num_req_p));

    brg_cgra_link_arbiter_rr #(
        .num_req_p (num_req_p)
    ) rr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (link.req_v_i),
        .yumi_i  (grant_en),
        .grant_o (grant_oh),
        .id_o    (grant_id)
    );

    assign link.req_yumi_o = grant_en ? grant_oh : '0;

    always_comb begin
        link.rsp_v_o = '0;
        if (rsp_ok) link.rsp_v_o[link.rsp_id_i] = 1'b1;
    end

    assign link.rsp_data_o = link.rsp_data_i;
    assign link.out_v_o    = (state_r == OUT_FULL);
    assign link.out_pkt_o  = out_pkt_r;
    assign link.out_id_o   = out_id_r;
    assign link.credits_o  = credits_r;
    assign link.idle_o     = (credits_r == max_credits_lp) && (state_r == OUT_EMPTY);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r   <= OUT_EMPTY;
            out_pkt_r <= '0;
            out_id_r  <= '0;
            credits_r <= max_credits_lp;
        end else begin
            if (grant_en) begin
                state_r   <= OUT_FULL;
                out_pkt_r <= link.req_pkt_i[grant_id];
                out_id_r  <= grant_id;
            end else if (state_r == OUT_FULL && link.out_ready_i) begin
                state_r   <= OUT_EMPTY;
            end

            // Spurious responses at full credit saturate instead of wrapping.
            if (grant_en && !rsp_ok) begin
                credits_r <= credits_r - one_credit_lp;
            end else if (rsp_ok && !grant_en && credits_r != max_credits_lp) begin
                credits_r <= credits_r + one_credit_lp;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i && link.rsp_v_i) begin
            if (credits_r == max_credits_lp)
                $error("brg_cgra_link_arbiter: response with no outstanding request");
            if (32'(link.rsp_id_i) >= 32'(num_req_p))
                $error("brg_cgra_link_arbiter: response id %0d out of range", link.rsp_id_i);
        end
    end
`endif

endmodule

// File: doc/brg_cgra_link_arbiter.md
Name: brg_cgra_link_arbiter

Overview:
Shares one manycore endpoint forward link among num_req_p CGRA requesters inside the CGRA xcel tile. The requesters are the per-CGRA memory ports that sit ahead of the per-row async CDC.
- Grants requests round-robin and registers the winner into a one-entry output stage.
- Tracks outstanding remote requests with a credit counter bounded by max_out_credits_p.
- Steers each returning response to its originating requester using the requester id.

Parameters:
num_req_p, 4, number of requesters sharing the link (>=2)
pkt_width_p, 128, forward packet width (opaque; bsg_manycore_packet_s bits)
rsp_width_p, 64, response payload width (opaque; bsg_manycore_return_packet_s bits)
max_out_credits_p, 16, maximum outstanding requests (>=1)
lg_num_req_lp, `BSG_SAFE_CLOG2(num_req_p), requester id width (derived)
credit_width_lp, `BSG_WIDTH(max_out_credits_p), credit counter width (derived)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
req_v_i  in  num_req_p  per-requester request valid
req_pkt_i  in  num_req_p x pkt_width_p  per-requester request packet
req_yumi_o  out  num_req_p  request accepted this cycle (one-hot or zero)
out_v_o  out  1  output packet valid
out_pkt_o  out  pkt_width_p  registered winning packet
out_id_o  out  lg_num_req_lp  requester id of out_pkt_o (carried in reg_id by the tile)
out_ready_i  in  1  downstream link ready
rsp_v_i  in  1  response valid (always consumed)
rsp_id_i  in  lg_num_req_lp  requester id of the response
rsp_data_i  in  rsp_width_p  response payload
rsp_v_o  out  num_req_p  one-hot response valid to the addressed requester
rsp_data_o  out  rsp_width_p  response payload, broadcast to all requesters
credits_o  out  credit_width_lp  available credits
idle_o  out  1  no outstanding requests and output stage empty

Behaviour:
- Reset is synchronous active-high and only one clock is used. On reset:
  - out_v_o=0, req_yumi_o=0, rsp_v_o=0.
  - credits_o=max_out_credits_p, idle_o=1.
  - Round-robin priority pointer = 0.
- Output stage is a one-entry register with states EMPTY and FULL.
  - Dequeue occurs when out_v_o & out_ready_i.
  - The stage can accept a new packet when it is EMPTY, or when it is FULL and dequeuing this cycle (pass-through, full throughput).
- Grant condition: the output stage can accept, credits_o != 0, and at least one req_v_i is set.
  - The winner is the first set requester at or after the priority pointer, searching with wrap-around.
  - req_yumi_o[winner]=1 in the same cycle, combinationally from req_v_i.
  - The winner's packet and id are registered; out_v_o=1 on the next cycle, so latency is 1 cycle.
  - The pointer moves to (winner+1) mod num_req_p only on a grant. Otherwise it holds.
- While FULL and out_ready_i=0, out_pkt_o and out_id_o must stay stable and no grant is made.
- Credit counter:
  - Decrements by 1 on each grant.
  - Increments by 1 on each rsp_v_i.
  - A grant and a response in the same cycle leave it unchanged.
  - credits_o==0 blocks all grants. A response in that cycle frees a credit for the next cycle, not the current one; no combinational rsp-to-grant path.
- Response path is purely combinational:
  - rsp_v_o[rsp_id_i]=rsp_v_i.
  - rsp_data_o=rsp_data_i.
  - No backpressure.
- Error cases:
  - rsp_v_i while credits_o==max_out_credits_p: the counter saturates, and a simulation $error is raised under `ifndef SYNTHESIS.
  - rsp_id_i >= num_req_p: the response is dropped and $error is raised.
- idle_o = (credits_o==max_out_credits_p) & ~out_v_o.
- req_v_i may drop without a yumi; the arbiter holds no per-request state before the grant.
- Reset asserted mid-operation discards the registered packet, restores all credits, and clears the pointer. Responses already in flight are then spurious and fall under the error rule above.

Decomposition:
- No new package. Widths come from bsg_manycore_pkg (`declare_bsg_manycore_packet_s` defines the packet sizes at the tile level).
- One natural sub-module: the round-robin grant logic, implemented with bsg_arb_round_robin (width_p=num_req_p) with yumi_i tied to the grant condition.
- Credit counter: bsg_counter_up_down, max_val_p=max_out_credits_p, init_val_p=max_out_credits_p.

Test Plan:
- Single requester: req_v_i=4'b0010, out_ready_i=1 -> yumi[1] in cycle 0, out_v_o=1 with out_id_o=1 in cycle 1, credits_o 16->15.
- All requesters valid continuously, out_ready_i=1, 8 cycles, no responses -> grant order 0,1,2,3,0,1,2,3 at one per cycle; credits_o=8.
- Backpressure: out_ready_i=0 for 5 cycles with a FULL stage -> out_pkt_o stable, no yumi; out_ready_i=1 -> dequeue and new grant in the same cycle.
- Credit exhaustion, max_out_credits_p=2: third request is blocked (credits_o=0) until rsp_v_i pulses; grant occurs the following cycle, and rsp_v_o is one-hot at rsp_id_i.
- Simultaneous grant and response with credits_o=5 -> credits_o stays 5; rsp_v_o[2]=1 for rsp_id_i=2 with rsp_data_i forwarded unchanged.
- Reset mid-operation with out_v_o=1 and credits_o=3 -> next cycle out_v_o=0, credits_o=16, idle_o=1; first grant afterwards starts at requester 0.
